// File: rtl/dp_defs.sv
// Shared datapath definitions: mux mode constants and width helpers
// reused by the parametrised datapath components.
package dp_defs;

  localparam int MUX_MODE_SEL = 0;
  localparam int MUX_MODE_RR  = 1;

  function automatic int clog2(input int n);
    for (int r = 0; r < 31; r++) begin
      if ((1 << r) >= n) return r;
    end
    return 31;
  endfunction

  // Select-field width: never narrower than one bit, even for tiny N.
  function automatic int selw(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or above ptr,
// wrapping around, and reports it as one-hot, as an index, or as none.
module rr_arbiter
  import dp_defs::*;
#(
  parameter int NUM_IN = 4,
  parameter int SELW   = selw(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SELW-1:0]   ptr,
  output logic [NUM_IN-1:0] gnt,
  output logic [SELW-1:0]   idx,
  output logic              none
);

  always_comb begin
    int pos;
    gnt  = '0;
    idx  = '0;
    none = 1'b1;
    pos  = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_IN) pos = pos - NUM_IN;
      if (none && req[pos]) begin
        gnt[pos] = 1'b1;
        idx      = SELW'(pos);
        none     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/muxn_reg.sv
// N-input registered multiplexer with valid/ready on every channel; the
// channel comes from sel (MODE 0) or a round-robin arbiter (MODE 1).
module muxn_reg
  import dp_defs::*;
#(
  parameter int DATAWIDTH = 16,
  parameter int NUM_IN    = 4,
  parameter int MODE      = MUX_MODE_SEL,
  parameter int SELW      = selw(NUM_IN)
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic [NUM_IN*DATAWIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]           in_valid,
  output logic [NUM_IN-1:0]           in_ready,
  input  logic [SELW-1:0]             sel,
  output logic [DATAWIDTH-1:0]        out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SELW-1:0]             grant
);

  logic                 load_en;
  logic                 cand;
  logic                 xfer;
  logic [SELW-1:0]      ch;
  logic [NUM_IN-1:0]    pick;
  logic [DATAWIDTH-1:0] pick_data;

  assign load_en = !out_valid || out_ready;

  generate
    if (MODE == MUX_MODE_RR) begin : g_rr
      logic [SELW-1:0]   ptr;
      logic [NUM_IN-1:0] gnt;
      logic [SELW-1:0]   idx;
      logic              none;
      logic              sel_unused;

      assign sel_unused = ^sel;

      rr_arbiter #(
        .NUM_IN(NUM_IN),
        .SELW  (SELW)
      ) u_arb (
        .req (in_valid),
        .ptr (ptr),
        .gnt (gnt),
        .idx (idx),
        .none(none)
      );

      assign cand = !none;
      assign ch   = idx;
      assign pick = gnt;

      // Pointer moves just past the winner so it has lowest priority next time.
      always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
          ptr <= '0;
        end else if (xfer) begin
          ptr <= (int'(ch) == NUM_IN - 1) ? '0 : ch + 1'b1;
        end
      end
    end else begin : g_sel
      assign cand = int'(sel) < NUM_IN;
      assign ch   = sel;
      assign pick = NUM_IN'(1) << sel;
    end
  endgenerate

  assign in_ready = (load_en && cand) ? pick : '0;
  assign xfer     = |(in_ready & in_valid);

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (pick[i]) pick_data = in_data[i*DATAWIDTH +: DATAWIDTH];
    end
  end

  // Output stage: load on transfer, empty when drained with nothing to load.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      grant     <= '0;
    end else if (load_en) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= pick_data;
        grant    <= ch;
      end
    end
  end

endmodule

// File: doc/muxn_reg.md
# muxn_reg

Parametrised N-input registered multiplexer with a valid/ready stream handshake on every input and on the output. It is the next generation of the datapath 2-to-1 mux. It selects one of `NUM_IN` channels, either from an external select (mode 0) or by round-robin arbitration (mode 1), and latches the winner into an output register. It sits between the datapath generator's functional units and shared consumers such as registers, the ALU input or the output port, where several producers contend for one sink.

## Interface
- `DATAWIDTH`, 16, width of each data word.
- `NUM_IN`, 4, number of input channels; legal range 2..16.
- `MODE`, 0, 0 = select-driven (`sel` chooses the channel), 1 = round-robin arbitration (`sel` is ignored).
- `SELW`, derived as clog2(`NUM_IN`) with a minimum of 1; not to be overridden.

Ports. One clock; reset is asynchronous and active-low.
- `Clk`  in  1  clock; all state updates on the rising edge.
- `Rst`  in  1  asynchronous, active-low reset.
- `in_data`  in  NUM_IN*DATAWIDTH  packed inputs; channel i occupies bits [i*DATAWIDTH +: DATAWIDTH].
- `in_valid`  in  NUM_IN  per-channel valid.
- `in_ready`  out  NUM_IN  per-channel ready (combinational).
- `sel`  in  SELW  channel select; used only when MODE=0.
- `out_data`  out  DATAWIDTH  registered output word.
- `out_valid`  out  1  registered output valid.
- `out_ready`  in  1  downstream ready.
- `grant`  out  SELW  registered index of the channel held in `out_data`.

## Operation
- `load_en` = !out_valid || out_ready. The output register can accept a new word whenever it is empty or is being drained this cycle.
- Chosen channel `ch`:
  - MODE 0: `ch` = `sel`. If `sel` >= NUM_IN, there is no candidate: all `in_ready` = 0 and nothing loads.
  - MODE 1: `ch` is the first i with `in_valid[i]`=1, searching from `ptr` upward with wrap-around (ptr, ptr+1, …, NUM_IN-1, 0, …, ptr-1). If no input is valid, there is no candidate.
- `in_ready[i]` = load_en && candidate exists && (i == ch). All other channels see 0.
  - MODE 0: `in_ready[sel]` does not depend on `in_valid[sel]`.
  - MODE 1: ready is asserted only on the valid winner.
- Transfer on channel i happens when in_valid[i] && in_ready[i]. On a transfer, at the next edge:
  - `out_data` <= in_data[ch]
  - `out_valid` <= 1
  - `grant` <= ch
  - MODE 1 only: `ptr` <= (ch == NUM_IN-1) ? 0 : ch+1
- If load_en holds and no transfer occurs: `out_valid` <= 0. `out_data` and `grant` hold their last values.
- If load_en = 0 (output stalled): all registers hold and all `in_ready` = 0.
- Output words follow AXI-style rules: once `out_valid` = 1, `out_data` and `grant` stay stable until out_valid && out_ready.
- Changing `sel` while the output is stalled has no effect until `load_en` rises.

## Timing
- Reset values (asynchronous, while `Rst` = 0): out_valid = 0, out_data = 0, grant = 0, ptr = 0.
- Asserting reset mid-transfer discards the held word with no partial state. The first transfer after reset release occurs at the first edge with a candidate present.
- Latency: an input accepted at edge k appears on `out_data`/`out_valid` after edge k, i.e. 1 cycle.
- Throughput: 1 word per cycle while `out_ready` is held at 1; no bubble between back-to-back transfers.
- Combinational paths:
  - `out_ready` → `in_ready`
  - `in_valid` → `in_ready` (MODE 1)
  - `sel` → `in_ready` (MODE 0)
  - There is no combinational path from any input to `out_data` or `out_valid`.
- Simultaneous drain and load in one cycle (out_valid = 1, out_ready = 1, candidate valid): the old word is consumed and the new word is loaded in that same cycle.
- Fairness in MODE 1: with all NUM_IN inputs held valid, every channel is granted exactly once in any NUM_IN consecutive transfers.

## Structure
- Shared package/header `dp_defs`:
  - `MUX_MODE_SEL` = 0 and `MUX_MODE_RR` = 1 constants.
  - A clog2 function, reused by other parametrised components.
- Sub-module `rr_arbiter` (NUM_IN requests, ptr → one-hot grant plus index and a "none" flag).
  - Instantiated only under generate when MODE = 1.
  - In MODE 0 the candidate logic is a simple range check on `sel`.
- The output register and `load_en` logic stay in `muxn_reg`.

## Test plan
- Reset: drive Rst = 0 with random inputs → out_valid = 0, out_data = 0, grant = 0 during reset and on the first edge after release.
- MODE 0, NUM_IN = 4, DATAWIDTH = 16: in_data = {0xDDDD, 0xCCCC, 0xBBBB, 0xAAAA}, all valid, sel = 2, out_ready = 1 → one cycle later out_data = 0xCCCC, grant = 2; in_ready = 4'b0100.
- MODE 0, sel = 3 with NUM_IN = 3 → in_ready = 0; out_valid falls to 0 after the current word drains; no load.
- Backpressure: hold out_ready = 0 for 5 cycles after a load → out_data is stable, in_ready = 0 throughout; raising out_ready gives drain and reload in the same cycle.
- MODE 1, all 4 inputs valid, out_ready = 1 for 8 cycles → grant sequence 0, 1, 2, 3, 0, 1, 2, 3 with no bubbles.
- MODE 1, only channels 1 and 3 valid, ptr = 2 → first grant 3, then 1, then 3; channel 0 and channel 2 never see in_ready = 1.
